// File: rtl/tx_zc_para_calc_mc.sv
// Multi-channel ZC parameter calculator: one request at a time, shared 17-cycle restoring divider.
// Optional build macro ZC_CFG_CHK_EN adds input range checking on cfg_err.
module tx_zc_para_calc_mc #(
    parameter int unsigned NZC_W = 11,
    parameter int unsigned CH_W  = 2
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH_W-1:0]    in_ch,
    input  logic [4:0]         in_u,
    input  logic               in_v,
    input  logic [3:0]         in_alpha,
    input  logic [NZC_W-1:0]   in_nzc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_ch,
    output logic [NZC_W-1:0]   out_q,
    output logic [NZC_W+3:0]   zc_Q,
    output logic [NZC_W+4:0]   zc_P,
    output logic               busy,
    output logic               cfg_err
);

    localparam int unsigned X_W   = 17;
    localparam int unsigned Q_W   = NZC_W + 4;
    localparam int unsigned P_W   = NZC_W + 5;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned DIV_LAST = 16;

    typedef enum logic [2:0] {S_IDLE, S_PROD, S_DIV, S_ADJ, S_MOD} state_t;

    state_t               state_q, state_nx;
    logic [CH_W-1:0]      ch_r;
    logic [4:0]           u_r;
    logic                 v_r;
    logic [3:0]           alpha_r;
    logic [NZC_W-1:0]     nzc_r;
    logic [X_W-1:0]       dq_r, dq_nx;
    logic [4:0]           rem_r, rem_nx;
    logic [CNT_W-1:0]     cnt_r, cnt_nx;
    logic [NZC_W-1:0]     q_r, q_nx;
    logic                 out_valid_nx;
    logic [CH_W-1:0]      out_ch_nx;
    logic [NZC_W-1:0]     out_q_nx;
    logic [Q_W-1:0]       zc_q_nx;
    logic [P_W-1:0]       zc_p_nx;
    logic                 in_ready_nx;

    logic                 accept_c;
    logic [X_W-1:0]       prod_c;
    logic [5:0]           trial_c;
    logic [X_W-1:0]       d_half_c;
    logic [X_W-1:0]       q_long_c;
    logic [P_W-1:0]       n24_c;
    logic [P_W-1:0]       q12_c;
    logic [4:0]           k_c;
    logic [P_W-1:0]       zp_c;

    assign accept_c = in_valid & in_ready;

    // X = 2*Nzc*(u+1)
    assign prod_c   = X_W'(X_W'(nzc_r) * (X_W'(u_r) + X_W'(1))) << 1;
    assign trial_c  = {rem_r, dq_r[X_W-1]};
    assign d_half_c = X_W'(dq_r + X_W'(1)) >> 1;
    assign q_long_c = dq_r[0] ? (d_half_c - X_W'(v_r)) : (d_half_c + X_W'(v_r));
    assign n24_c    = (P_W'(nzc_r) << 4) + (P_W'(nzc_r) << 3);
    assign q12_c    = (P_W'(q_r) << 3) + (P_W'(q_r) << 2);
    assign k_c      = 5'(5'd23 - {alpha_r, 1'b0});

    // (23-2alpha)*Nzc as a shift-add over the 5-bit multiplier
    always_comb begin
        zp_c = '0;
        for (int i = 0; i < 5; i++) begin
            if (k_c[i]) zp_c = zp_c + (P_W'(nzc_r) << i);
        end
    end

    // Next-state and datapath
    always_comb begin
        state_nx     = state_q;
        dq_nx        = dq_r;
        rem_nx       = rem_r;
        cnt_nx       = cnt_r;
        q_nx         = q_r;
        out_valid_nx = out_valid;
        out_ch_nx    = out_ch;
        out_q_nx     = out_q;
        zc_q_nx      = zc_Q;
        zc_p_nx      = zc_P;

        case (state_q)
            S_IDLE: begin
                if (out_valid && out_ready) out_valid_nx = 1'b0;
                if (accept_c) state_nx = S_PROD;
            end
            S_PROD: begin
                dq_nx    = prod_c;
                rem_nx   = '0;
                cnt_nx   = '0;
                state_nx = S_DIV;
            end
            S_DIV: begin
                if (trial_c >= 6'd31) begin
                    rem_nx = 5'(trial_c - 6'd31);
                    dq_nx  = {dq_r[X_W-2:0], 1'b1};
                end else begin
                    rem_nx = trial_c[4:0];
                    dq_nx  = {dq_r[X_W-2:0], 1'b0};
                end
                if (cnt_r == CNT_W'(DIV_LAST)) state_nx = S_ADJ;
                else cnt_nx = cnt_r + CNT_W'(1);
            end
            S_ADJ: begin
                if (nzc_r > NZC_W'(30)) q_nx = NZC_W'(q_long_c);
                else q_nx = NZC_W'(u_r) + NZC_W'(1);
                state_nx = S_MOD;
            end
            S_MOD: begin
                out_valid_nx = 1'b1;
                out_ch_nx    = ch_r;
                out_q_nx     = q_r;
                zc_q_nx      = (q_r == '0) ? '0 : Q_W'(n24_c - q12_c);
                zc_p_nx      = zp_c;
                state_nx     = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        in_ready_nx = (state_nx == S_IDLE) && !out_valid_nx;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ch_r      <= '0;
            u_r       <= '0;
            v_r       <= 1'b0;
            alpha_r   <= '0;
            nzc_r     <= '0;
            dq_r      <= '0;
            rem_r     <= '0;
            cnt_r     <= '0;
            q_r       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_q     <= '0;
            zc_Q      <= '0;
            zc_P      <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nx;
            dq_r      <= dq_nx;
            rem_r     <= rem_nx;
            cnt_r     <= cnt_nx;
            q_r       <= q_nx;
            out_valid <= out_valid_nx;
            out_ch    <= out_ch_nx;
            out_q     <= out_q_nx;
            zc_Q      <= zc_q_nx;
            zc_P      <= zc_p_nx;
            in_ready  <= in_ready_nx;
            busy      <= !in_ready_nx;
            if (accept_c) begin
                ch_r    <= in_ch;
                u_r     <= in_u;
                v_r     <= in_v;
                alpha_r <= in_alpha;
                nzc_r   <= in_nzc;
            end
        end
    end

`ifdef ZC_CFG_CHK_EN
    logic err_r;
    logic cfg_err_r;

    // Range flag captured at accept, presented alongside the result
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r     <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            if (accept_c)
                err_r <= (in_u > 5'd29) || (in_alpha > 4'd11) || (in_nzc < NZC_W'(12)) ||
                         (in_v && (in_nzc <= NZC_W'(30)));
            if (state_q == S_MOD) cfg_err_r <= err_r;
            else if (out_valid && out_ready) cfg_err_r <= 1'b0;
        end
    end

    assign cfg_err = cfg_err_r;
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_zc_para_calc_mc.sv
// Directed vector bench for tx_zc_para_calc_mc: latency, results, backpressure, reset abort.
module tb_tx_zc_para_calc_mc;

    logic         sys_clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_ch;
    logic [4:0]   in_u;
    logic         in_v;
    logic [3:0]   in_alpha;
    logic [10:0]  in_nzc;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_ch;
    logic [10:0]  out_q;
    logic [14:0]  zc_Q;
    logic [15:0]  zc_P;
    logic         busy;
    logic         cfg_err;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [4:0]  u;
        logic        v;
        logic [3:0]  alpha;
        logic [10:0] nzc;
        int          q;
        int          zq;
        int          zp;
        int          err;
    } vec_t;

    vec_t vecs[9];

    tx_zc_para_calc_mc #(.NZC_W(11), .CH_W(2)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_u     (in_u),
        .in_v     (in_v),
        .in_alpha (in_alpha),
        .in_nzc   (in_nzc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_q    (out_q),
        .zc_Q     (zc_Q),
        .zc_P     (zc_P),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic drive(input vec_t t);
        in_ch    = t.ch;
        in_u     = t.u;
        in_v     = t.v;
        in_alpha = t.alpha;
        in_nzc   = t.nzc;
        in_valid = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, " ready"}, 32'(in_ready), 32'd1);
    endtask

    // Caller has in_valid high with in_ready seen at a negedge; this crosses the accept edge
    task automatic accept_edge;
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge sys_clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input vec_t t, input int cyc);
        check({name, " latency"}, 32'(cyc), 32'd20);
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " out_ch"}, 32'(out_ch), 32'(t.ch));
        check({name, " out_q"}, 32'(out_q), 32'(t.q));
        check({name, " zc_Q"}, 32'(zc_Q), 32'(t.zq));
        check({name, " zc_P"}, 32'(zc_P), 32'(t.zp));
        check({name, " cfg_err"}, 32'(cfg_err), 32'(t.err));
    endtask

    task automatic run_vec(input string name, input vec_t t);
        int cyc;
        wait_ready(name);
        drive(t);
        accept_edge();
        check({name, " busy"}, 32'(busy), 32'd1);
        wait_out(cyc);
        check_result(name, t, cyc);
    endtask

    int cexp;
    vec_t snap;
    int cyc;

    initial begin
        int chk_err;
`ifdef ZC_CFG_CHK_EN
        chk_err = 1;
`else
        chk_err = 0;
`endif
        //           ch    u      v     alpha  nzc        q     zc_Q   zc_P   err
        vecs[0] = '{2'd1, 5'd0,  1'b0, 4'd0,  11'd139,  4,    3288,  3197,  0};
        vecs[1] = '{2'd2, 5'd1,  1'b1, 4'd11, 11'd139,  8,    3240,  139,   0};
        vecs[2] = '{2'd3, 5'd0,  1'b1, 4'd0,  11'd139,  5,    3276,  3197,  0};
        vecs[3] = '{2'd0, 5'd0,  1'b1, 4'd0,  11'd31,   2,    720,   713,   0};
        vecs[4] = '{2'd1, 5'd5,  1'b0, 4'd3,  11'd12,   6,    216,   204,   0};
        vecs[5] = '{2'd2, 5'd29, 1'b0, 4'd5,  11'd2047, 1981, 25356, 26611, 0};
        vecs[6] = '{2'd3, 5'd29, 1'b0, 4'd11, 11'd30,   30,   360,   30,    0};
        vecs[7] = '{2'd0, 5'd29, 1'b0, 4'd0,  11'd31,   30,   384,   713,   0};
        vecs[8] = '{2'd1, 5'd30, 1'b0, 4'd0,  11'd139,  139,  1668,  3197,  chk_err};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ch = '0; in_u = '0; in_v = 1'b0; in_alpha = '0; in_nzc = '0;
        repeat (3) @(negedge sys_clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst zc_P", 32'(zc_P), 32'd0);
        rst_n = 1'b1;
        @(negedge sys_clk);
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // Backpressure: result held 10 cycles, second request waits
        @(negedge sys_clk);
        out_ready = 1'b0;
        run_vec("bp_a", vecs[0]);
        drive(vecs[1]);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check($sformatf("bp hold%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp hold%0d q", i), 32'(out_q), 32'd4);
            check($sformatf("bp hold%0d zc_Q", i), 32'(zc_Q), 32'd3288);
            check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge sys_clk);
        check("bp release valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        accept_edge();
        wait_out(cyc);
        check_result("bp_b", vecs[1], cyc);

        // Reset in the middle of the divide
        @(negedge sys_clk);
        wait_ready("rst_mid");
        drive(vecs[2]);
        accept_edge();
        repeat (6) @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid in_ready", 32'(in_ready), 32'd0);
        check("rst_mid out_valid", 32'(out_valid), 32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            @(negedge sys_clk);
            cyc++;
        end
        check("rst_mid no result", 32'(out_valid), 32'd0);
        run_vec("after_rst", vecs[3]);

        @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
